mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 103 ++++++++++
 tb/tb_mem_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX->MEM bus, extracts load data from the
// synchronous data SRAM, and drives the WB and ID-forwarding buses.
module mem_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [139:0] ex_to_mem_bus,
    input  logic [31:0]  data_sram_rdata,
    output logic [135:0] mem_to_wb_bus,
    output logic [103:0] mem_to_id_bus
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned LDTYPE_W = 3;

    localparam logic [LDTYPE_W-1:0] LD_B  = 3'd1;
    localparam logic [LDTYPE_W-1:0] LD_BU = 3'd2;
    localparam logic [LDTYPE_W-1:0] LD_H  = 3'd3;
    localparam logic [LDTYPE_W-1:0] LD_HU = 3'd4;
    localparam logic [LDTYPE_W-1:0] LD_W  = 3'd5;

    typedef struct packed {
        logic                hi_we;
        logic                lo_we;
        logic [DATA_W-1:0]   hi_result;
        logic [DATA_W-1:0]   lo_result;
        logic [DATA_W-1:0]   pc;
        logic                data_ram_en;
        logic [LDTYPE_W-1:0] load_type;
        logic                rf_we;
        logic [ADDR_W-1:0]   rf_waddr;
        logic [DATA_W-1:0]   ex_result;
    } ex_mem_t;

    ex_mem_t           ex_to_mem_r;
    logic [DATA_W-1:0] rdata_hold;
    logic              hold_valid;

    logic              stop_mem;
    logic              bubble;
    logic              is_load_c;
    logic [DATA_W-1:0] rdata_eff;
    logic [DATA_W-1:0] rf_wdata;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic              unused_stall;

    assign stop_mem     = stall[3];
    assign bubble       = stall[3] & ~stall[4];
    assign unused_stall = ^{stall[5], stall[2:0]};

    assign is_load_c = ex_to_mem_r.data_ram_en &&
                       (ex_to_mem_r.load_type >= LD_B) &&
                       (ex_to_mem_r.load_type <= LD_W);

    // Pipeline register plus capture of SRAM data while a load is held in MEM
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_to_mem_r <= '0;
            rdata_hold  <= '0;
            hold_valid  <= 1'b0;
        end else if (bubble) begin
            ex_to_mem_r <= '0;
            hold_valid  <= 1'b0;
        end else if (!stop_mem) begin
            ex_to_mem_r <= ex_mem_t'(ex_to_mem_bus);
            hold_valid  <= 1'b0;
        end else if (is_load_c && !hold_valid) begin
            rdata_hold  <= data_sram_rdata;
            hold_valid  <= 1'b1;
        end
    end

    // SRAM read data is only valid for one cycle; later held cycles use the copy
    assign rdata_eff = hold_valid ? rdata_hold : data_sram_rdata;
    assign byte_sel  = rdata_eff[{ex_to_mem_r.ex_result[1:0], 3'b000} +: 8];
    assign half_sel  = ex_to_mem_r.ex_result[1] ? rdata_eff[31:16] : rdata_eff[15:0];

    always_comb begin
        rf_wdata = ex_to_mem_r.ex_result;
        if (ex_to_mem_r.data_ram_en) begin
            case (ex_to_mem_r.load_type)
                LD_B:    rf_wdata = {{24{byte_sel[7]}}, byte_sel};
                LD_BU:   rf_wdata = {24'd0, byte_sel};
                LD_H:    rf_wdata = {{16{half_sel[15]}}, half_sel};
                LD_HU:   rf_wdata = {16'd0, half_sel};
                LD_W:    rf_wdata = rdata_eff;
                default: rf_wdata = ex_to_mem_r.ex_result;
            endcase
        end
    end

    assign mem_to_wb_bus = {ex_to_mem_r.hi_we, ex_to_mem_r.lo_we,
                            ex_to_mem_r.hi_result, ex_to_mem_r.lo_result,
                            ex_to_mem_r.pc, ex_to_mem_r.rf_we,
                            ex_to_mem_r.rf_waddr, rf_wdata};

    assign mem_to_id_bus = {ex_to_mem_r.hi_we, ex_to_mem_r.lo_we,
                            ex_to_mem_r.hi_result, ex_to_mem_r.lo_result,
                            ex_to_mem_r.rf_we, ex_to_mem_r.rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized traffic
// compared against a behavioural model of the MEM stage.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [139:0] ex_bus;
    logic [31:0]  rdata;
    logic [135:0] wb;
    logic [103:0] id;

    int total = 0;
    int bad   = 0;

    // model state: the instruction sitting in MEM and any captured load data
    logic [139:0] m_reg;
    logic         m_held;
    logic [31:0]  m_data;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .ex_to_mem_bus  (ex_bus),
        .data_sram_rdata(rdata),
        .mem_to_wb_bus  (wb),
        .mem_to_id_bus  (id)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [139:0] mk(input logic hi_we, input logic lo_we,
                                        input logic [31:0] hi, input logic [31:0] lo,
                                        input logic [31:0] pc, input logic en,
                                        input logic [2:0] lt, input logic we,
                                        input logic [4:0] wa, input logic [31:0] res);
        return {hi_we, lo_we, hi, lo, pc, en, lt, we, wa, res};
    endfunction

    function automatic bit model_is_load(input logic [139:0] r);
        int unsigned lt;
        lt = int'(r[40:38]);
        return (r[41] == 1'b1) && (lt >= 1) && (lt <= 5);
    endfunction

    function automatic logic [31:0] model_load(input int unsigned lt, input int unsigned addr,
                                               input logic [31:0] rd);
        int unsigned word, b, h;
        word = rd;
        b = (word >> (8 * addr)) % 256;
        h = (word >> (16 * (addr / 2))) % 65536;
        case (lt)
            1:       return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            2:       return b;
            3:       return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            4:       return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata();
        logic [31:0] rd;
        rd = m_held ? m_data : rdata;
        if (model_is_load(m_reg))
            return model_load(int'(m_reg[40:38]), int'(m_reg[1:0]), rd);
        return m_reg[31:0];
    endfunction

    function automatic logic [135:0] exp_wb();
        return {m_reg[139:42], m_reg[37:32], model_wdata()};
    endfunction

    function automatic logic [103:0] exp_id();
        return {m_reg[139:74], m_reg[37:32], model_wdata()};
    endfunction

    // One clock: advance the model with the inputs seen at the edge, present
    // this cycle's SRAM data, then compare both buses.
    task automatic cycle(input logic [31:0] rd_now);
        @(posedge clk);
        if (rst) begin
            m_reg = '0; m_held = 1'b0; m_data = '0;
        end else if (stall[3] && !stall[4]) begin
            m_reg = '0; m_held = 1'b0;
        end else if (!stall[3]) begin
            m_reg = ex_bus; m_held = 1'b0;
        end else if (model_is_load(m_reg) && !m_held) begin
            m_held = 1'b1; m_data = rdata;
        end
        #1 rdata = rd_now;
        #1;
        check_eq("wb_bus", wb, exp_wb());
        check_eq("id_bus", 136'(id), 136'(exp_id()));
    endtask

    initial begin
        m_reg = '0; m_held = 1'b0; m_data = '0;
        rst = 1'b1; stall = 6'd0; rdata = 32'hCAFE_F00D;
        ex_bus = mk(1, 1, 32'h1, 32'h2, 32'h3, 1, 3'd5, 1, 5'd7, 32'h4);

        // reset state
        cycle(32'h0BAD_0BAD);
        cycle(32'h0BAD_0BAD);
        check_eq("reset_wb", wb, 136'd0);
        check_eq("reset_id", 136'(id), 136'd0);
        rst = 1'b0;

        // sign-extending byte load from lane 2
        ex_bus = mk(0, 0, 0, 0, 32'h0040_0010, 1, 3'd1, 1, 5'd5, 32'h1000_0002);
        cycle(32'h1280_3456);
        check_eq("lb_wdata", 136'(wb[31:0]), 136'(32'hFFFF_FF80));
        check_eq("lb_we_addr", 136'(wb[37:32]), 136'({1'b1, 5'd5}));

        // halfword loads from the upper half
        ex_bus = mk(0, 0, 0, 0, 32'h0040_0014, 1, 3'd4, 1, 5'd6, 32'h1000_0002);
        cycle(32'h8001_7FFF);
        check_eq("lhu_wdata", 136'(wb[31:0]), 136'(32'h0000_8001));
        ex_bus = mk(0, 0, 0, 0, 32'h0040_0018, 1, 3'd3, 1, 5'd6, 32'h1000_0003);
        cycle(32'h8001_7FFF);
        check_eq("lh_wdata", 136'(wb[31:0]), 136'(32'hFFFF_8001));

        // lw held in MEM for three edges while SRAM output changes
        ex_bus = mk(0, 0, 0, 0, 32'h0040_001C, 1, 3'd5, 1, 5'd9, 32'h1000_0001);
        cycle(32'hAAAA_AAAA);
        check_eq("lw_first", 136'(wb[31:0]), 136'(32'hAAAA_AAAA));
        stall  = 6'b011111;
        ex_bus = mk(1, 1, 32'h9, 32'h9, 32'h9, 0, 3'd0, 1, 5'd1, 32'h9);
        for (int i = 0; i < 3; i++) begin
            cycle(32'h5555_5555);
            check_eq("lw_held", 136'(wb[31:0]), 136'(32'hAAAA_AAAA));
        end

        // bubble: MEM stops while WB proceeds
        stall = 6'b001111;
        cycle(32'h1111_2222);
        check_eq("bubble_wb", wb, 136'd0);
        check_eq("bubble_id", 136'(id), 136'd0);

        // non-memory instruction passes straight through
        stall  = 6'd0;
        ex_bus = mk(1, 0, 32'hDEAD_BEEF, 32'h0, 32'h0040_0020, 0, 3'd1, 1, 5'd3, 32'h1234_5678);
        cycle(32'h7777_7777);
        check_eq("pass_wdata", 136'(wb[31:0]), 136'(32'h1234_5678));
        check_eq("pass_hi", 136'({wb[135], wb[133:102]}), 136'({1'b1, 32'hDEAD_BEEF}));
        check_eq("pass_id_hi", 136'(id[103:0]),
                 136'({1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1, 5'd3, 32'h1234_5678}));

        // reset while a held load is in flight
        ex_bus = mk(0, 0, 0, 0, 32'h0040_0024, 1, 3'd5, 1, 5'd4, 32'h1000_0000);
        cycle(32'hBEEF_0001);
        stall = 6'b011111;
        cycle(32'hBEEF_0002);
        check_eq("held_pre_rst", 136'(wb[31:0]), 136'(32'hBEEF_0001));
        rst = 1'b1;
        cycle(32'hBEEF_0003);
        check_eq("rst_mid_stall", wb, 136'd0);
        rst   = 1'b0;
        stall = 6'd0;
        cycle(32'h1357_9BDF);
        check_eq("lw_after_rst", 136'(wb[31:0]), 136'(32'h1357_9BDF));

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [139:0] r;
            rst = ($urandom_range(0, 39) == 0);
            stall = 6'($urandom);
            stall[3] = ($urandom_range(0, 9) < 4);
            stall[4] = ($urandom_range(0, 9) < 7);
            r = {$urandom, $urandom, $urandom, $urandom, $urandom};
            r[41] = ($urandom_range(0, 1) == 1);
            ex_bus = r;
            cycle($urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
